// File: rtl/iss_pkg.sv
// Shared ISS defaults used by the issue queue, busy table and LSQ.
package iss_pkg;

  localparam int unsigned DEF_DEPTH         = 8;
  localparam int unsigned DEF_PREG_BITS     = 6;
  localparam int unsigned DEF_ROB_BITS      = 6;
  localparam int unsigned DEF_PAYLOAD_WIDTH = 64;
  localparam int unsigned DEF_WAKE_PORTS    = 3;
  localparam int unsigned DEF_CNT_BITS      = 5;

endpackage

// File: rtl/iss_wake_match.sv
// Compares one physical register against every wakeup port.
module iss_wake_match
  import iss_pkg::*;
#(
  parameter int unsigned PREG_BITS  = DEF_PREG_BITS,
  parameter int unsigned WAKE_PORTS = DEF_WAKE_PORTS
) (
  input  logic [PREG_BITS-1:0]            preg,
  input  logic [WAKE_PORTS-1:0]           wake_valid,
  input  logic [WAKE_PORTS*PREG_BITS-1:0] wake_preg,
  output logic                            hit_c
);

  // Any valid port carrying this register is a hit.
  always_comb begin
    hit_c = 1'b0;
    for (int k = 0; k < int'(WAKE_PORTS); k++) begin
      if (wake_valid[k] && (wake_preg[k*PREG_BITS +: PREG_BITS] == preg)) begin
        hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iss_wakeup_queue.sv
// Collapsing, age-ordered issue queue with multi-port wakeup and oldest-ready select.
module iss_wakeup_queue
  import iss_pkg::*;
#(
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned PREG_BITS     = DEF_PREG_BITS,
  parameter int unsigned ROB_BITS      = DEF_ROB_BITS,
  parameter int unsigned PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH,
  parameter int unsigned WAKE_PORTS    = DEF_WAKE_PORTS,
  parameter int unsigned CNT_BITS      = DEF_CNT_BITS
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            FREEZE,
  input  logic                            FLUSH_IN,
  input  logic                            push_valid_IN,
  output logic                            push_ready_OUT,
  input  logic [PREG_BITS-1:0]            push_src1_IN,
  input  logic                            push_src1_rdy_IN,
  input  logic [PREG_BITS-1:0]            push_src2_IN,
  input  logic                            push_src2_rdy_IN,
  input  logic [ROB_BITS-1:0]             push_rob_IN,
  input  logic [PAYLOAD_WIDTH-1:0]        push_payload_IN,
  input  logic [WAKE_PORTS-1:0]           wake_valid_IN,
  input  logic [WAKE_PORTS*PREG_BITS-1:0] wake_preg_IN,
  output logic                            issue_valid_OUT,
  input  logic                            issue_ready_IN,
  output logic [ROB_BITS-1:0]             issue_rob_OUT,
  output logic [PAYLOAD_WIDTH-1:0]        issue_payload_OUT,
  output logic [CNT_BITS-1:0]             count_OUT,
  output logic                            empty_OUT,
  output logic                            full_OUT
);

  logic [DEPTH-1:0]         valid, rdy1, rdy2, hit1, hit2;
  logic [DEPTH-1:0]         n_valid, n_rdy1, n_rdy2;
  logic [PREG_BITS-1:0]     src1 [DEPTH];
  logic [PREG_BITS-1:0]     src2 [DEPTH];
  logic [PREG_BITS-1:0]     n_src1 [DEPTH];
  logic [PREG_BITS-1:0]     n_src2 [DEPTH];
  logic [ROB_BITS-1:0]      rob [DEPTH];
  logic [ROB_BITS-1:0]      n_rob [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] n_payload [DEPTH];
  logic [CNT_BITS-1:0]      count, n_count, slot, sel_idx;
  logic                     sel_found, full, push_fire, issue_fire;
  logic                     push_hit1, push_hit2;

  // Wakeup comparators: two per entry plus two for the incoming micro-op.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_match
    iss_wake_match #(.PREG_BITS(PREG_BITS), .WAKE_PORTS(WAKE_PORTS)) u_m1 (
      .preg(src1[i]), .wake_valid(wake_valid_IN), .wake_preg(wake_preg_IN), .hit_c(hit1[i]));
    iss_wake_match #(.PREG_BITS(PREG_BITS), .WAKE_PORTS(WAKE_PORTS)) u_m2 (
      .preg(src2[i]), .wake_valid(wake_valid_IN), .wake_preg(wake_preg_IN), .hit_c(hit2[i]));
  end

  iss_wake_match #(.PREG_BITS(PREG_BITS), .WAKE_PORTS(WAKE_PORTS)) u_push_m1 (
    .preg(push_src1_IN), .wake_valid(wake_valid_IN), .wake_preg(wake_preg_IN), .hit_c(push_hit1));
  iss_wake_match #(.PREG_BITS(PREG_BITS), .WAKE_PORTS(WAKE_PORTS)) u_push_m2 (
    .preg(push_src2_IN), .wake_valid(wake_valid_IN), .wake_preg(wake_preg_IN), .hit_c(push_hit2));

  assign full            = (count == CNT_BITS'(DEPTH));
  assign full_OUT        = full;
  assign empty_OUT       = (count == '0);
  assign count_OUT       = count;
  assign push_ready_OUT  = !full && !FREEZE && !FLUSH_IN;
  assign issue_valid_OUT = sel_found && !FREEZE && !FLUSH_IN;
  assign push_fire       = push_valid_IN && push_ready_OUT;
  assign issue_fire      = issue_valid_OUT && issue_ready_IN;
  assign slot            = count - CNT_BITS'(issue_fire);

  // Oldest-ready select: lowest index wins, so scan downward and keep overwriting.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (valid[i] && rdy1[i] && rdy2[i]) begin
        sel_found = 1'b1;
        sel_idx   = CNT_BITS'(i);
      end
    end
  end

  // Issue data mux; zero when nothing is selectable.
  always_comb begin
    issue_rob_OUT     = '0;
    issue_payload_OUT = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sel_found && (sel_idx == CNT_BITS'(i))) begin
        issue_rob_OUT     = rob[i];
        issue_payload_OUT = payload[i];
      end
    end
  end

  // Next state: wakeup everywhere, collapse above the issued slot, then append the push.
  always_comb begin
    n_valid = valid;
    n_rdy1  = rdy1 | hit1;
    n_rdy2  = rdy2 | hit2;
    n_count = count;
    for (int i = 0; i < int'(DEPTH); i++) begin
      n_src1[i]    = src1[i];
      n_src2[i]    = src2[i];
      n_rob[i]     = rob[i];
      n_payload[i] = payload[i];
    end

    if (issue_fire) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (CNT_BITS'(i) >= sel_idx) begin
          n_valid[i]   = valid[i+1];
          n_rdy1[i]    = rdy1[i+1] | hit1[i+1];
          n_rdy2[i]    = rdy2[i+1] | hit2[i+1];
          n_src1[i]    = src1[i+1];
          n_src2[i]    = src2[i+1];
          n_rob[i]     = rob[i+1];
          n_payload[i] = payload[i+1];
        end
      end
      n_valid[DEPTH-1] = 1'b0;
    end

    if (push_fire) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CNT_BITS'(i) == slot) begin
          n_valid[i]   = 1'b1;
          n_rdy1[i]    = push_src1_rdy_IN | push_hit1;
          n_rdy2[i]    = push_src2_rdy_IN | push_hit2;
          n_src1[i]    = push_src1_IN;
          n_src2[i]    = push_src2_IN;
          n_rob[i]     = push_rob_IN;
          n_payload[i] = push_payload_IN;
        end
      end
    end

    if (push_fire && !issue_fire) begin
      n_count = count + CNT_BITS'(1);
    end else if (issue_fire && !push_fire) begin
      n_count = count - CNT_BITS'(1);
    end

    if (FLUSH_IN) begin
      n_valid = '0;
      n_count = '0;
    end
  end

  // State registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        src1[i]    <= '0;
        src2[i]    <= '0;
        rob[i]     <= '0;
        payload[i] <= '0;
      end
    end else begin
      valid <= n_valid;
      rdy1  <= n_rdy1;
      rdy2  <= n_rdy2;
      count <= n_count;
      for (int i = 0; i < int'(DEPTH); i++) begin
        src1[i]    <= n_src1[i];
        src2[i]    <= n_src2[i];
        rob[i]     <= n_rob[i];
        payload[i] <= n_payload[i];
      end
    end
  end

endmodule
